// File: rtl/adsr_pkg.sv
// Shared constants and state encoding for the ADSR amplitude envelope.
package adsr_pkg;

    localparam int unsigned DEF_FRAC_BITS = 20;
    localparam int unsigned ENV_W         = 21;
    localparam int unsigned SAMPLE_W      = 32;

    localparam logic [ENV_W-1:0] ONE = ENV_W'(1 << DEF_FRAC_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/adsr_envelope_amp_multiplier.sv
// Two-stage registered signed sample x unsigned envelope scaler.
module amp_multiplier
    import adsr_pkg::*;
#(
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic        [ENV_W-1:0]    env,
    output logic signed [SAMPLE_W-1:0] sample_out
);

    localparam int unsigned PROD_W = SAMPLE_W + ENV_W;

    logic signed [SAMPLE_W-1:0] s1_sample;
    logic        [ENV_W-1:0]    s1_env;
    logic signed [PROD_W-1:0]   product;
    logic signed [SAMPLE_W-1:0] scaled;

    // Envelope is zero-extended so it always acts as a non-negative gain.
    always_comb begin
        product = PROD_W'(s1_sample) * PROD_W'($signed({1'b0, s1_env}));
        scaled  = SAMPLE_W'(product >>> FRAC_BITS);
    end

    // Stage 1 captures operands, stage 2 captures the scaled product.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_sample  <= '0;
            s1_env     <= '0;
            sample_out <= '0;
        end else begin
            s1_sample  <= sample_in;
            s1_env     <= env;
            sample_out <= scaled;
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: tick-paced state machine plus amplitude scaling.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
    parameter int unsigned TICK_DIV  = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       gate,
    input  logic        [ENV_W-1:0]    attack_step,
    input  logic        [ENV_W-1:0]    decay_step,
    input  logic        [ENV_W-1:0]    sustain_level,
    input  logic        [ENV_W-1:0]    release_step,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic        [ENV_W-1:0]    env_level,
    output logic        [2:0]          env_state,
    output logic                       active
);

    localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned     ARITH_W = ENV_W + 1;
    localparam logic [ENV_W-1:0] ENV_ONE = ENV_W'(1 << FRAC_BITS);

    env_state_t         state;
    env_state_t         state_next;
    logic [ENV_W-1:0]   env;
    logic [ENV_W-1:0]   env_next;
    logic [CNT_W-1:0]   tick_cnt;
    logic [CNT_W-1:0]   tick_cnt_next;
    logic               gate_d;
    logic               active_reg;
    logic               tick;
    logic               rise;
    logic               fall;
    logic [ENV_W-1:0]   sustain;
    logic [ARITH_W-1:0] att_sum;
    logic [ARITH_W-1:0] dec_diff;
    logic [ARITH_W-1:0] rel_diff;

    // Tick pacing, edge detection and 22-bit step arithmetic.
    always_comb begin
        tick          = (tick_cnt == CNT_W'(TICK_DIV - 1));
        tick_cnt_next = tick ? '0 : tick_cnt + CNT_W'(1);
        rise          = gate & ~gate_d;
        fall          = ~gate & gate_d;
        sustain       = (sustain_level > ENV_ONE) ? ENV_ONE : sustain_level;
        att_sum       = {1'b0, env} + {1'b0, attack_step};
        dec_diff      = {1'b0, env} - {1'b0, decay_step};
        rel_diff      = {1'b0, env} - {1'b0, release_step};
    end

    // Next-state and next-envelope; gate edges take priority over tick steps.
    always_comb begin
        state_next = state;
        env_next   = env;
        if (rise) begin
            state_next = ATTACK;
        end else if (fall && state != IDLE) begin
            state_next = RELEASE;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    env_next = '0;
                end
                ATTACK: begin
                    if (attack_step == '0 || att_sum >= {1'b0, ENV_ONE}) begin
                        env_next   = ENV_ONE;
                        state_next = DECAY;
                    end else begin
                        env_next = att_sum[ENV_W-1:0];
                    end
                end
                DECAY: begin
                    if (decay_step == '0 || dec_diff[ENV_W] || dec_diff[ENV_W-1:0] <= sustain) begin
                        env_next   = sustain;
                        state_next = SUSTAIN;
                    end else begin
                        env_next = dec_diff[ENV_W-1:0];
                    end
                end
                SUSTAIN: begin
                    env_next = sustain;
                end
                RELEASE: begin
                    if (release_step == '0 || rel_diff[ENV_W] || rel_diff[ENV_W-1:0] == '0) begin
                        env_next   = '0;
                        state_next = IDLE;
                    end else begin
                        env_next = rel_diff[ENV_W-1:0];
                    end
                end
                default: begin
                    env_next   = '0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Envelope state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            env        <= '0;
            tick_cnt   <= '0;
            gate_d     <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state      <= state_next;
            env        <= env_next;
            tick_cnt   <= tick_cnt_next;
            gate_d     <= gate;
            active_reg <= (state_next != IDLE);
        end
    end

    assign env_level = env;
    assign env_state = 3'(state);
    assign active    = active_reg;

    amp_multiplier #(
        .FRAC_BITS (FRAC_BITS)
    ) u_amp (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_in  (sample_in),
        .env        (env),
        .sample_out (sample_out)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with TICK_DIV=4.
module tb_adsr_envelope;
    import adsr_pkg::*;

    localparam int unsigned TICK_DIV = 4;

    logic               clk;
    logic               reset_n;
    logic               gate;
    logic [20:0]        attack_step;
    logic [20:0]        decay_step;
    logic [20:0]        sustain_level;
    logic [20:0]        release_step;
    logic signed [31:0] sample_in;
    logic signed [31:0] sample_out;
    logic [20:0]        env_level;
    logic [2:0]         env_state;
    logic               active;

    int n_tests;
    int n_fail;
    int k;

    adsr_envelope #(
        .FRAC_BITS (20),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .env_level     (env_level),
        .env_state     (env_state),
        .active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_env(input string tag, input logic [31:0] exp_env, input logic [31:0] exp_state);
        check({tag, " env"}, 32'(env_level), exp_env);
        check({tag, " state"}, 32'(env_state), exp_state);
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance through the next tick edge (every TICK_DIV-th edge after reset).
    task automatic to_tick();
        step();
        while (k % int'(TICK_DIV) != 0) step();
    endtask

    logic [31:0] ads_env   [6];
    logic [31:0] ads_state [6];
    logic [31:0] rel_env   [3];
    logic [31:0] rel_state [3];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        k       = 0;
        ads_env   = '{32'h4_0000, 32'h8_0000, 32'hC_0000, 32'h10_0000, 32'hC_0000, 32'h8_0000};
        ads_state = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3};
        rel_env   = '{32'h5_0000, 32'h2_0000, 32'h0};
        rel_state = '{32'd4, 32'd4, 32'd0};

        // Reset held for three clocks.
        reset_n       = 1'b0;
        gate          = 1'b0;
        attack_step   = '0;
        decay_step    = '0;
        sustain_level = '0;
        release_step  = '0;
        sample_in     = 32'h0010_0000;
        steps(3);
        check("rst sample_out", 32'(sample_out), 32'h0);
        check_env("rst", 32'h0, 32'd0);
        check("rst active", 32'(active), 32'd0);
        reset_n = 1'b1;
        k = 0;

        // Attack / decay / sustain.
        attack_step   = 21'h4_0000;
        decay_step    = 21'h4_0000;
        sustain_level = 21'h8_0000;
        gate          = 1'b1;
        step();
        check_env("gate rise", 32'h0, 32'd1);
        check("gate rise active", 32'(active), 32'd1);
        for (int i = 0; i < 6; i++) begin
            to_tick();
            check_env($sformatf("ads tick%0d", i), ads_env[i], ads_state[i]);
        end
        steps(2);
        check("sustain sample_out", 32'(sample_out), 32'h0008_0000);

        // Release with negative sample.
        gate         = 1'b0;
        release_step = 21'h3_0000;
        sample_in    = 32'hFFF0_0000;
        step();
        check_env("gate fall", 32'h8_0000, 32'd4);
        to_tick();
        check_env("rel tick0", rel_env[0], rel_state[0]);
        steps(2);
        check("rel neg sample_out", 32'(sample_out), 32'hFFFB_0000);
        for (int i = 1; i < 3; i++) begin
            to_tick();
            check_env($sformatf("rel tick%0d", i), rel_env[i], rel_state[i]);
        end
        check("rel done active", 32'(active), 32'd0);

        // Zero steps and sustain clamp.
        attack_step   = '0;
        decay_step    = '0;
        sustain_level = 21'h1F_FFFF;
        sample_in     = 32'h0012_3457;
        gate          = 1'b1;
        step();
        check_env("zero rise", 32'h0, 32'd1);
        to_tick();
        check_env("zero attack", 32'h10_0000, 32'd2);
        to_tick();
        check_env("zero decay", 32'h10_0000, 32'd3);
        to_tick();
        check_env("clamp sustain", 32'h10_0000, 32'd3);
        check("unity sample_out", 32'(sample_out), 32'h0012_3457);

        // Retrigger from release on a tick cycle.
        gate         = 1'b0;
        release_step = 21'h5_0000;
        step();
        check_env("fall2", 32'h10_0000, 32'd4);
        to_tick();
        check_env("rel2 tick0", 32'hB_0000, 32'd4);
        to_tick();
        check_env("rel2 tick1", 32'h6_0000, 32'd4);
        steps(int'(TICK_DIV) - 1);
        gate        = 1'b1;
        attack_step = 21'h2_0000;
        step();
        check("retrig on tick", 32'(k % int'(TICK_DIV)), 32'd0);
        check_env("retrig", 32'h6_0000, 32'd1);
        to_tick();
        check_env("retrig step", 32'h8_0000, 32'd1);

        // Reset mid-attack clears state and both pipeline stages.
        reset_n = 1'b0;
        step();
        check_env("midrst", 32'h0, 32'd0);
        check("midrst active", 32'(active), 32'd0);
        check("midrst sample_out", 32'(sample_out), 32'h0);
        reset_n = 1'b1;
        k = 0;
        step();
        check_env("post rst gate high", 32'h0, 32'd1);
        check("post rst sample_out", 32'(sample_out), 32'h0);
        step();
        check("post rst sample_out2", 32'(sample_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
